// File: rtl/mux4_rr.sv
// mux4_rr: four-channel round-robin arbiter/mux feeding a one-entry output
// register with valid/ready handshakes on both sides and a handshake counter.
module mux4_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready,
  output logic [15:0]        xfer_cnt
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                  state, state_nxt;
  logic [1:0]              ptr;
  logic [3:0][WIDTH-1:0]   chan;
  logic [3:0][1:0]         cand;
  logic                    load, any_vld, grant;
  logic [1:0]              gnt_idx;

  assign chan = in_data;

  // Search order: candidate i is the channel ptr+i (mod 4, via 2-bit wrap).
  for (genvar i = 0; i < 4; i++) begin : g_cand
    assign cand[i] = ptr + 2'(i);
  end

  // First valid channel in search order; scanning backwards lets the
  // lowest search position overwrite later ones.
  always_comb begin
    any_vld = 1'b0;
    gnt_idx = ptr;
    for (int i = 3; i >= 0; i--) begin
      if (in_valid[cand[i]]) begin
        any_vld = 1'b1;
        gnt_idx = cand[i];
      end
    end
  end

  assign load  = !out_valid || out_ready;
  assign grant = load && any_vld;

  // One-hot accept strobe at the granted channel; forced low during reset
  // since load would otherwise be 1 with the register empty.
  always_comb begin
    in_ready = 4'b0000;
    if (grant && rst_n) in_ready[gnt_idx] = 1'b1;
  end

  // Output register occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_nxt;
  end

  // EMPTY fills on a grant; FULL holds on stall, refills or empties on drain.
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (grant) state_nxt = FULL;
      FULL:    if (out_ready) state_nxt = grant ? FULL : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Occupancy drives the output valid directly.
  always_comb begin
    out_valid = (state == FULL);
  end

  // Capture granted word and advance the pointer past the winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= 2'b00;
      ptr      <= 2'b00;
    end else if (grant) begin
      out_data <= chan[gnt_idx];
      out_sel  <= gnt_idx;
      ptr      <= gnt_idx + 2'd1;
    end
  end

  // Count completed output handshakes, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      xfer_cnt <= 16'h0000;
    else if (out_valid && out_ready) xfer_cnt <= xfer_cnt + 16'h0001;
  end

endmodule
